// File: rtl/ascon_pack.sv
// ASCON permutation state type and constant tables.
// Shared by the round datapath and the permutation sequencer.
package ascon_pack;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  // Entries 12..15 are never applied in RUN; they only keep the 4-bit lookup total.
  localparam logic [7:0] round_constant [16] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
    8'h78, 8'h69, 8'h5a, 8'h4b, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Round count per mode_i encoding; the reserved code runs the full 12 rounds.
  localparam logic [3:0] mode_rounds [4] = '{4'd12, 4'd8, 4'd6, 4'd12};

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One ASCON round: constant addition, bitsliced 5-bit S-box layer, linear diffusion.
// Purely combinational, zero latency; no flow control.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state,
  input  logic [3:0] round_idx,
  output type_state  next_state
);

  logic [63:0] c2;
  logic [63:0] a0, a2, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] s0, s1, s2, s3, s4;

  assign c2 = {state.x2[63:8], state.x2[7:0] ^ round_constant[round_idx]};

  // S-box applied to all 64 bit columns in parallel.
  assign a0 = state.x0 ^ state.x4;
  assign a4 = state.x4 ^ state.x3;
  assign a2 = c2 ^ state.x1;

  assign b0 = a0 ^ (~state.x1 & a2);
  assign b1 = state.x1 ^ (~a2 & state.x3);
  assign b2 = a2 ^ (~state.x3 & a4);
  assign b3 = state.x3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & state.x1);

  assign s0 = b0 ^ b4;
  assign s1 = b1 ^ b0;
  assign s2 = ~b2;
  assign s3 = b3 ^ b2;
  assign s4 = b4;

  assign next_state.x0 = s0 ^ ror64(s0, 19) ^ ror64(s0, 28);
  assign next_state.x1 = s1 ^ ror64(s1, 61) ^ ror64(s1, 39);
  assign next_state.x2 = s2 ^ ror64(s2, 1)  ^ ror64(s2, 6);
  assign next_state.x3 = s3 ^ ror64(s3, 10) ^ ror64(s3, 17);
  assign next_state.x4 = s4 ^ ror64(s4, 7)  ^ ror64(s4, 41);

endmodule

// File: rtl/permutation_iter.sv
// Iterative ASCON permutation (12/8/6 rounds), UNROLL rounds per clock.
// Latency N/UNROLL cycles to a one-cycle valid_o; no backpressure, start_i ignored while busy_o.
module permutation_iter
  import ascon_pack::*;
#(
  parameter int        UNROLL      = 1,
  parameter type_state RESET_STATE = '0
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       valid_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [3:0] LAST = 4'd12;
  localparam logic [3:0] STEP = 4'(UNROLL);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("permutation_iter: UNROLL must be 1 or 2");
  end

  logic [0:0] fsm_q;
  logic [3:0] round_q;
  logic [3:0] round_nxt;
  logic       valid_q;
  type_state  state_q;
  type_state  chain [UNROLL+1];

  assign chain[0] = state_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    ascon_round u_round (
      .state      (chain[g]),
      .round_idx  (round_q + 4'(g)),
      .next_state (chain[g+1])
    );
  end

  // Every round count is a multiple of UNROLL, so the index lands exactly on 12.
  assign round_nxt = round_q + STEP;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= RESET_STATE;
      round_q <= LAST;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (fsm_q == IDLE) begin
        if (start_i) begin
          state_q <= state_i;
          round_q <= LAST - mode_rounds[mode_i];
          fsm_q   <= RUN;
        end
      end else begin
        state_q <= chain[UNROLL];
        round_q <= round_nxt;
        if (round_nxt >= LAST) begin
          fsm_q   <= IDLE;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign state_o = state_q;
  assign round_o = round_q;
  assign busy_o  = (fsm_q == RUN);
  assign valid_o = valid_q;

endmodule

// File: tb/tb_permutation_iter.sv
// Bench for permutation_iter: UNROLL=1 and UNROLL=2 instances checked every cycle
// against a table-driven reference permutation, plus directed literal checks.
module tb_permutation_iter;
  import ascon_pack::*;

  localparam type_state RST2 = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0,
                                64'hffffffffffffffff, 64'hdeadbeefcafef00d};
  // One round (index 0) applied to the all-zero state, worked out by hand.
  localparam type_state LIT1 = {64'h001e0f00000000f0, 64'h00000001e0000770,
                                64'h3fffffffffffff74, 64'h3c780000000000f0, 64'h0};
  localparam type_state S_IV = {64'h80400c0600000000, 64'h0001020304050607,
                                64'h08090a0b0c0d0e0f, 64'h1011121314151617, 64'h18191a1b1c1d1e1f};
  localparam type_state SA = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
                              64'h4444444444444444, 64'h5555555555555555};
  localparam type_state SB = {64'hffffffff00000000, 64'h0, 64'h0, 64'h0, 64'h0000000000000001};
  localparam type_state SC = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100, 64'haaaaaaaaaaaaaaaa,
                              64'h5555555555555555, 64'h0123012301230123};
  localparam type_state SD = {64'hcafebabe00000000, 64'h00000000deadbeef, 64'h8000000000000000,
                              64'h0000000000000001, 64'h7fffffffffffffff};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start  [2];
  logic [1:0] mode   [2];
  type_state  st_in  [2];
  type_state  st_out [2];
  logic [3:0] rnd    [2];
  logic       busy   [2];
  logic       vld    [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  permutation_iter #(.UNROLL(1)) u_dut1 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start[0]), .mode_i(mode[0]), .state_i(st_in[0]),
    .state_o(st_out[0]), .round_o(rnd[0]), .busy_o(busy[0]), .valid_o(vld[0])
  );

  permutation_iter #(.UNROLL(2), .RESET_STATE(RST2)) u_dut2 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start[1]), .mode_i(mode[1]), .state_i(st_in[1]),
    .state_o(st_out[1]), .round_o(rnd[1]), .busy_o(busy[1]), .valid_o(vld[1])
  );

  // ---------------- reference permutation ----------------
  logic [4:0] sbox_tbl [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic type_state ref_round(input type_state s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  idx;
    logic [4:0]  o;
    type_state   t;
    x[0] = s.x0; x[1] = s.x1; x[2] = s.x2; x[3] = s.x3; x[4] = s.x4;
    x[2][7:0] = x[2][7:0] ^ {4'(15 - r), 4'(r)};
    for (int k = 0; k < 5; k++) y[k] = '0;
    for (int b = 0; b < 64; b++) begin
      idx = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o   = sbox_tbl[idx];
      for (int k = 0; k < 5; k++) y[k][b] = o[4-k];
    end
    t.x0 = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
    t.x1 = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
    t.x2 = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
    t.x3 = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
    t.x4 = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    return t;
  endfunction

  function automatic type_state ref_apply(input type_state s, input int r0, input int n);
    type_state t = s;
    for (int r = r0; r < r0 + n; r++) t = ref_round(t, r);
    return t;
  endfunction

  function automatic int rounds_of(input logic [1:0] m);
    case (m)
      2'b01:   return 8;
      2'b10:   return 6;
      default: return 12;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit        m_act  [2];
  bit        m_vld  [2];
  type_state m_init [2];
  type_state m_hold [2];
  int        m_r0   [2];
  int        m_n    [2];
  int        m_k    [2];

  task automatic m_reset(input int i);
    m_act[i]  = 1'b0;
    m_vld[i]  = 1'b0;
    m_hold[i] = (i == 0) ? type_state'('0) : RST2;
    m_k[i]    = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) m_reset(i);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_reset(i);
        end else if (m_act[i]) begin
          m_k[i]++;
          if (m_k[i] * (i + 1) == m_n[i]) begin
            m_act[i]  = 1'b0;
            m_vld[i]  = 1'b1;
            m_hold[i] = ref_apply(m_init[i], m_r0[i], m_n[i]);
          end
        end else begin
          m_vld[i] = 1'b0;
          if (start[i]) begin
            m_act[i]  = 1'b1;
            m_init[i] = st_in[i];
            m_n[i]    = rounds_of(mode[i]);
            m_r0[i]   = 12 - m_n[i];
            m_k[i]    = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        type_state es;
        int        er;
        es = m_act[i] ? ref_apply(m_init[i], m_r0[i], m_k[i] * (i + 1)) : m_hold[i];
        er = m_act[i] ? m_r0[i] + m_k[i] * (i + 1) : 12;
        chk($sformatf("u%0d state_o", i + 1), st_out[i], es);
        chk_i($sformatf("u%0d round_o", i + 1), int'(rnd[i]), er);
        chk_i($sformatf("u%0d busy_o", i + 1), int'(busy[i]), int'(m_act[i]));
        chk_i($sformatf("u%0d valid_o", i + 1), int'(vld[i]), int'(m_vld[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic go(input int i, input logic [1:0] md, input type_state s);
    start[i] = 1'b1;
    mode[i]  = md;
    st_in[i] = s;
    @(posedge clk);
    #2;
    start[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int k0, output int k);
    k = k0;
    forever begin
      @(negedge clk);
      if (vld[i]) return;
      k++;
      if (k > 40) begin
        chk_i("valid_timeout", 0, 1);
        return;
      end
    end
  endtask

  int lat;
  int lat2 [3] = '{6, 4, 3};
  int nr   [3] = '{12, 8, 6};

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; mode[i] = 2'b00; st_in[i] = '0;
    end

    chk("model_pin_round0", ref_round(type_state'('0), 0), LIT1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("reset round_o", int'(rnd[0]), 12);
    chk("reset state u2", st_out[1], RST2);
    chk_i("reset busy_o", int'(busy[0]), 0);
    chk_i("reset valid_o", int'(vld[1]), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 12 rounds of the zero state, start on the first edge after release
    go(0, 2'b00, '0);
    @(negedge clk);
    chk_i("t1 busy", int'(busy[0]), 1);
    chk_i("t1 round0", int'(rnd[0]), 0);
    @(negedge clk);
    chk("t1 one round", st_out[0], LIT1);
    wait_valid(0, 2, lat);
    chk_i("t1 latency", lat, 12);
    chk("t1 p12(0)", st_out[0], ref_apply('0, 0, 12));
    repeat (3) @(negedge clk);
    chk("t1 hold", st_out[0], ref_apply('0, 0, 12));
    chk_i("t1 hold valid", int'(vld[0]), 0);

    // 6 rounds of the IV/key/nonce state, round index walks 6..12
    go(0, 2'b10, S_IV);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk_i("t2 round seq", int'(rnd[0]), 6 + c);
    end
    wait_valid(0, 6, lat);
    chk_i("t2 latency", lat, 6);
    chk_i("t2 round end", int'(rnd[0]), 12);
    chk("t2 p6", st_out[0], ref_apply(S_IV, 6, 6));

    // UNROLL=2 across the three round counts
    for (int j = 0; j < 3; j++) begin
      go(1, 2'(j), S_IV);
      wait_valid(1, 0, lat);
      chk_i("t3 u2 latency", lat, lat2[j]);
      chk("t3 u2 result", st_out[1], ref_apply(S_IV, 12 - nr[j], nr[j]));
    end

    // start with a different state mid-run must be ignored
    go(0, 2'b01, SA);
    repeat (3) @(negedge clk);
    start[0] = 1'b1; st_in[0] = SB; mode[0] = 2'b10;
    @(negedge clk);
    start[0] = 1'b0;
    wait_valid(0, 4, lat);
    chk_i("t4 latency", lat, 8);
    chk("t4 result", st_out[0], ref_apply(SA, 4, 8));

    // start held high through valid_o: back-to-back
    start[0] = 1'b1; mode[0] = 2'b10; st_in[0] = SC;
    @(posedge clk);
    #2;
    st_in[0] = SD; mode[0] = 2'b01;
    wait_valid(0, 0, lat);
    chk_i("t5 first latency", lat, 6);
    chk_i("t5 idle at valid", int'(busy[0]), 0);
    chk("t5 first result", st_out[0], ref_apply(SC, 6, 6));
    @(posedge clk);
    #2;
    start[0] = 1'b0;
    @(negedge clk);
    chk_i("t5 restart busy", int'(busy[0]), 1);
    chk_i("t5 restart round", int'(rnd[0]), 4);
    chk("t5 restart load", st_out[0], SD);
    wait_valid(0, 1, lat);
    chk_i("t5 second latency", lat, 8);
    chk("t5 second result", st_out[0], ref_apply(SD, 4, 8));

    // reset pulse at round 5 aborts the run
    go(0, 2'b00, S_IV);
    for (int c = 0; c < 6; c++) @(negedge clk);
    chk_i("t6 at round 5", int'(rnd[0]), 5);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6 abort state", st_out[0], '0);
    chk_i("t6 abort busy", int'(busy[0]), 0);
    chk_i("t6 abort round", int'(rnd[0]), 12);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk_i("t6 no valid", int'(vld[0]), 0);
    end
    go(0, 2'b00, SA);
    wait_valid(0, 0, lat);
    chk_i("t6 fresh latency", lat, 12);
    chk("t6 fresh result", st_out[0], ref_apply(SA, 0, 12));

    // reserved mode behaves as 12 rounds
    go(0, 2'b11, SB);
    wait_valid(0, 0, lat);
    chk_i("t7 u1 mode11 latency", lat, 12);
    chk("t7 u1 mode11 result", st_out[0], ref_apply(SB, 0, 12));
    go(1, 2'b11, SB);
    wait_valid(1, 0, lat);
    chk_i("t7 u2 mode11 latency", lat, 6);
    chk("t7 u2 mode11 result", st_out[1], ref_apply(SB, 0, 12));

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
